// File: rtl/rv_m_pkg.sv
// Shared definitions for the RV32M divide unit.
//   - funct3[1:0] opcode encodings for DIV/DIVU/REM/REMU
//   - divider FSM state encoding
//   - architectural special-case result constants
package rv_m_pkg;

  localparam logic [1:0] M_DIV  = 2'b00;
  localparam logic [1:0] M_DIVU = 2'b01;
  localparam logic [1:0] M_REM  = 2'b10;
  localparam logic [1:0] M_REMU = 2'b11;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } div_state_e;

  // DIV and REM treat their operands as two's complement; DIVU and REMU do not.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Remainder-type ops select the remainder instead of the quotient.
  function automatic logic is_rem_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/rv_div_step.sv
// One radix-2 restoring-division iteration (purely combinational).
//   rem          : current partial remainder (always < divisor)
//   dividend_msb : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   new_rem      : partial remainder after the trial subtraction
//   q_bit        : quotient bit produced by this iteration
module rv_div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dividend_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] new_rem,
  output logic            q_bit
);

  // The shifted remainder is XLEN+1 bits: with a divisor >= 2^(XLEN-1) the
  // shift can carry out of the top bit and must still take part in the compare.
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    shifted = {rem, dividend_msb};
    trial   = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    // Since rem < divisor, a successful trial always fits back in XLEN bits.
    new_rem = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/rv_div_unit.sv
// Iterative RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   start  : launch request, sampled only in idle
//   opcode : funct3[1:0] (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   op1    : dividend (rs1)
//   op2    : divisor (rs2)
//   kill   : pipeline flush, aborts an operation in flight
//   busy   : high while iterating / fixing up signs
//   done   : one-cycle pulse, result valid in the same cycle
//   result : quotient or remainder, held until overwritten by the next operation
// Normal operations take 34 cycles from start to done; divide-by-zero and
// signed overflow resolve in idle and pulse done on the following cycle.
module rv_div_unit
  import rv_m_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      opcode,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dvd_q starts as the dividend magnitude and fills with quotient bits from
  // the bottom as dividend bits leave the top; after XLEN steps it is the quotient.
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dsr_q, dsr_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             sel_rem_q, sel_rem_d;
  logic [XLEN-1:0]  result_q, result_d;

  logic [XLEN-1:0]  step_rem;
  logic             step_q_bit;

  logic             signed_op;
  logic             op1_neg;
  logic             op2_neg;
  logic             div_zero;
  logic             sgn_ovf;
  logic [XLEN-1:0]  quo_fixed;
  logic [XLEN-1:0]  rem_fixed;

  rv_div_step #(
    .XLEN(XLEN)
  ) u_step (
    .rem          (rem_q),
    .dividend_msb (dvd_q[XLEN-1]),
    .divisor      (dsr_q),
    .new_rem      (step_rem),
    .q_bit        (step_q_bit)
  );

  // Decode of the launch operands, only meaningful in idle.
  always_comb begin
    signed_op = is_signed_op(opcode);
    op1_neg   = signed_op & op1[XLEN-1];
    op2_neg   = signed_op & op2[XLEN-1];
    div_zero  = (op2 == '0);
    sgn_ovf   = signed_op && (op1 == INT_MIN) && (op2 == '1);
  end

  // Sign fix-up of the unsigned core results.
  always_comb begin
    quo_fixed = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_fixed = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    result_d  = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !kill) begin
          if (div_zero) begin
            result_d = is_rem_op(opcode) ? op1 : DIV_BY_ZERO_Q;
            state_d  = StDone;
          end else if (sgn_ovf) begin
            result_d = is_rem_op(opcode) ? '0 : INT_MIN;
            state_d  = StDone;
          end else begin
            sel_rem_d = is_rem_op(opcode);
            neg_quo_d = signed_op & (op1[XLEN-1] ^ op2[XLEN-1]);
            neg_rem_d = op1_neg;
            dvd_d     = op1_neg ? (~op1 + 1'b1) : op1;
            dsr_d     = op2_neg ? (~op2 + 1'b1) : op2;
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = StRun;
          end
        end
      end

      StRun: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          rem_d = step_rem;
          dvd_d = {dvd_q[XLEN-2:0], step_q_bit};
          if (cnt_q == '1) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StFix: begin
        if (kill) begin
          state_d = StIdle;
        end else begin
          result_d = sel_rem_q ? rem_fixed : quo_fixed;
          state_d  = StDone;
        end
      end

      StDone: begin
        // kill here is ignored: the done pulse is already on the output.
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    busy   = (state_q == StRun) || (state_q == StFix);
    done   = (state_q == StDone);
    result = result_q;
  end

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: directed cases, kill/reset scenarios
// and randomized operations, checked by a scoreboard fed from an arithmetic
// reference model.
module tb_rv_div_unit;
  import rv_m_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  opcode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  always #5 clk = ~clk;

  rv_div_unit #(
    .XLEN  (32),
    .CNT_W (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opcode (opcode),
    .op1    (op1),
    .op2    (op2),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned cyc0;
    int unsigned lat;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // RISC-V division semantics from plain 64-bit arithmetic: truncating signed
  // division, remainder follows the dividend, x/0 = all ones, x%0 = x.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=done required=no_done result=%h cycle=%0d",
                 result, cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("latency", cyc - e.cyc0, e.lat);
      end
    end
  end

  // Issue one operation and wait for its done. With junk set, random start
  // pulses and operand noise are applied while busy and must be ignored.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit junk);
    exp_t e;
    bit   fast;
    bit   busy_seen;
    bit   got;
    fast      = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    busy_seen = 1'b0;
    got       = 1'b0;
    @(posedge clk); #1;
    start  = 1'b1;
    opcode = op;
    op1    = a;
    op2    = b;
    e.res  = ref_model(op, a, b);
    e.cyc0 = cyc;
    e.lat  = fast ? 1 : 34;
    sb_q.push_back(e);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      busy_seen |= busy;
      if (junk && busy) begin
        start  = 1'($urandom_range(0, 1));
        opcode = 2'($urandom);
        op1    = $urandom;
        op2    = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    if (got) begin
      check("busy_seen", 32'(busy_seen), 32'(!fast));
      check("busy_in_done", 32'(busy), 32'd0);
      last_res = e.res;
    end else if (sb_q.size() != 0) begin
      void'(sb_q.pop_back());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    rst_n  = 1'b0;
    start  = 1'b0;
    kill   = 1'b0;
    opcode = 2'b00;
    op1    = '0;
    op2    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;

    // Directed cases.
    run_op(M_DIVU, 32'd100, 32'd7, 1'b0);
    run_op(M_REMU, 32'd100, 32'd7, 1'b0);
    run_op(M_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(M_REM, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(M_DIVU, 32'h1234_5678, 32'd0, 1'b0);
    run_op(M_REM, 32'h1234_5678, 32'd0, 1'b0);
    run_op(M_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(M_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(M_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(M_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    // INT_MIN / -1 is ordinary for the unsigned ops.
    run_op(M_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(M_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);

    // Kill during RUN: no done, result untouched.
    @(posedge clk); #1;
    start = 1'b1; opcode = M_DIVU; op1 = 32'd100; op2 = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_run_busy", 32'(busy), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("kill_run_result", result, last_res);
    run_op(M_DIVU, 32'd9, 32'd3, 1'b1);

    // Kill during FIX.
    @(posedge clk); #1;
    start = 1'b1; opcode = M_REM; op1 = 32'hFFFF_FF00; op2 = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    check("fix_busy", 32'(busy), 32'd1);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_fix_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("kill_fix_result", result, last_res);

    // start together with kill in idle is dropped, even on the fast path.
    start = 1'b1; kill = 1'b1; opcode = M_DIVU; op1 = 32'd5; op2 = 32'd0;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    check("start_kill_busy", 32'(busy), 32'd0);
    check("start_kill_done", 32'(done), 32'd0);
    check("start_kill_result", result, last_res);

    // Reset in the middle of an operation clears the result.
    start = 1'b1; opcode = M_DIV; op1 = 32'd1000; op2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_result", result, 32'd0);
    last_res = '0;

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 400) - 200; rb = $urandom_range(1, 20) - 10; end
        3: begin ra = $urandom; rb = $urandom_range(1, 255); end
        4: begin ra = $urandom; rb = 32'h8000_0000 | $urandom; end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      run_op(rop, ra, rb, n[0]);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
